// File: rtl/solve_fsm.sv
// Backtracking sudoku solver control: walks cells, proposes candidates to a conflict checker, writes or clears.
// Moore outputs, one cycle per state; waits in S_WAIT for i_chk_ack with no timeout.
module solve_fsm #(
  parameter int MAX_VAL = 9,
  parameter int VAL_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_init_done,
  input  logic             i_mark,
  input  logic [VAL_W-1:0] i_cell_value,
  input  logic             i_top,
  input  logic             i_bottom,
  input  logic             i_chk_ack,
  input  logic             i_chk_ok,
  output logic             solve_addr_inc,
  output logic             solve_addr_dec,
  output logic             solve_we_cell,
  output logic [VAL_W-1:0] solve_cell_value,
  output logic             solve_chk_req,
  output logic             solve_done,
  output logic             solve_fail
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_READ  = 4'd1;
  localparam logic [3:0] S_EVAL  = 4'd2;
  localparam logic [3:0] S_CHECK = 4'd3;
  localparam logic [3:0] S_WAIT  = 4'd4;
  localparam logic [3:0] S_WRITE = 4'd5;
  localparam logic [3:0] S_CLEAR = 4'd6;
  localparam logic [3:0] S_FWD   = 4'd7;
  localparam logic [3:0] S_BWD   = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;
  localparam logic [3:0] S_FAIL  = 4'd10;

  localparam logic [VAL_W:0] MAX_EXT = (VAL_W+1)'(MAX_VAL);
  localparam logic [VAL_W:0] ONE_EXT = (VAL_W+1)'(1);

  logic [3:0]       state, state_nxt;
  logic             dir, dir_nxt;
  logic [VAL_W-1:0] cand, cand_nxt;
  logic [VAL_W:0]   first_cand;

  // Extra bit keeps a stale 15 (or MAX_VAL+1) from wrapping back into the legal range.
  assign first_cand = dir ? ({1'b0, i_cell_value} + ONE_EXT) : ONE_EXT;

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    cand_nxt  = cand;
    case (state)
      S_IDLE: begin
        if (i_init_done) begin
          state_nxt = S_READ;
          dir_nxt   = 1'b0;
        end
      end
      S_READ:  state_nxt = S_EVAL;
      S_EVAL: begin
        if (i_mark) begin
          if (!dir) state_nxt = i_bottom ? S_DONE : S_FWD;
          else      state_nxt = i_top    ? S_FAIL : S_BWD;
        end else begin
          cand_nxt  = first_cand[VAL_W-1:0];
          state_nxt = (first_cand > MAX_EXT) ? S_CLEAR : S_CHECK;
        end
      end
      S_CHECK: state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_chk_ack) begin
          if (i_chk_ok) begin
            state_nxt = S_WRITE;
          end else if ({1'b0, cand} == MAX_EXT) begin
            state_nxt = S_CLEAR;
          end else begin
            cand_nxt  = cand + VAL_W'(1);
            state_nxt = S_CHECK;
          end
        end
      end
      S_WRITE: state_nxt = i_bottom ? S_DONE : S_FWD;
      S_CLEAR: state_nxt = i_top ? S_FAIL : S_BWD;
      S_FWD: begin
        dir_nxt   = 1'b0;
        state_nxt = S_READ;
      end
      S_BWD: begin
        dir_nxt   = 1'b1;
        state_nxt = S_READ;
      end
      S_DONE:  state_nxt = S_DONE;
      S_FAIL:  state_nxt = S_FAIL;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      dir   <= 1'b0;
      cand  <= '0;
    end else begin
      state <= state_nxt;
      dir   <= dir_nxt;
      cand  <= cand_nxt;
    end
  end

  always_comb begin
    solve_addr_inc   = (state == S_FWD);
    solve_addr_dec   = (state == S_BWD);
    solve_we_cell    = (state == S_WRITE) || (state == S_CLEAR);
    solve_chk_req    = (state == S_CHECK);
    solve_done       = (state == S_DONE);
    solve_fail       = (state == S_FAIL);
    solve_cell_value = '0;
    if ((state == S_CHECK) || (state == S_WAIT) || (state == S_WRITE))
      solve_cell_value = cand;
  end

endmodule

// File: tb/tb_solve_fsm.sv
// Bench for solve_fsm: emulates cell memory, address generator and a mask-based checker;
// a per-cell search model predicts the event stream (checks, writes, moves, terminal flag).
module tb_solve_fsm;
  localparam int MAXV = 9;
  localparam int W    = 4;
  localparam int NC   = 81;
  localparam int EV_CHK = 16, EV_WR = 32, EV_INC = 48, EV_DEC = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, init_done, chk_ack, chk_ok;
  logic addr_inc, addr_dec, we_cell, chk_req, done, fail;
  logic [W-1:0] cell_value;

  int addr;
  int mem_val [NC];
  bit mem_mark[NC];
  int mask    [NC];
  int tamp    [NC];

  logic         mark_w, top_w, bot_w;
  logic [W-1:0] val_w;
  assign mark_w = mem_mark[addr];
  assign val_w  = W'(mem_val[addr]);
  assign top_w  = (addr == 0);
  assign bot_w  = (addr == NC - 1);

  solve_fsm #(.MAX_VAL(MAXV), .VAL_W(W)) dut (
    .clk(clk), .rst(rst), .i_init_done(init_done), .i_mark(mark_w),
    .i_cell_value(val_w), .i_top(top_w), .i_bottom(bot_w),
    .i_chk_ack(chk_ack), .i_chk_ok(chk_ok),
    .solve_addr_inc(addr_inc), .solve_addr_dec(addr_dec), .solve_we_cell(we_cell),
    .solve_cell_value(cell_value), .solve_chk_req(chk_req),
    .solve_done(done), .solve_fail(fail)
  );

  int n_cmp = 0, n_bad = 0;
  int exp_q[$];
  int m_addr, term;
  int dmin, dmax;
  bit spur_en;
  int pend, dly, pend_val;
  int sched_delta, sched_wr, sched_wr_addr, sched_wr_val;
  int cyc, first_chk_cyc, first_we_cyc, first_inc_cyc, chk_before_we, post_dec_cand;
  bit seen_we, seen_dec;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {21'd0, addr_inc, addr_dec, we_cell, chk_req, done, fail, 1'b0, cell_value};
  endfunction

  // Expected behaviour of one cell visit: marked cells are passed through in the travel
  // direction; free cells try candidates upward and take the first one the checker likes.
  task automatic enter(input int a, input int d);
    int c, acc;
    if (mem_mark[a]) begin
      if (d == 0) begin
        if (a == NC - 1) term = 1; else exp_q.push_back(EV_INC);
      end else begin
        if (a == 0) term = 2; else exp_q.push_back(EV_DEC);
      end
    end else begin
      c   = (d == 0) ? 1 : mem_val[a] + 1;
      acc = -1;
      for (int v = c; v <= MAXV; v++)
        if (acc < 0 && ((mask[a] >> v) & 1) == 1) acc = v;
      if (acc >= 0) begin
        for (int v = c; v <= acc; v++) exp_q.push_back(EV_CHK + v);
        exp_q.push_back(EV_WR + acc);
        if (a == NC - 1) term = 1; else exp_q.push_back(EV_INC);
      end else begin
        for (int v = c; v <= MAXV; v++) exp_q.push_back(EV_CHK + v);
        exp_q.push_back(EV_WR);
        if (a == 0) term = 2; else exp_q.push_back(EV_DEC);
      end
    end
  endtask

  task automatic observe(input int obs);
    int e;
    if (exp_q.size() == 0) begin
      cmp("unexpected_event", obs, 0);
    end else begin
      e = exp_q.pop_front();
      cmp("event", obs, e);
      if (e == EV_INC) begin m_addr++; enter(m_addr, 0); end
      if (e == EV_DEC) begin m_addr--; enter(m_addr, 1); end
    end
  endtask

  task automatic monitor();
    cmp("inc_dec_excl", {31'd0, addr_inc & addr_dec}, 0);
    if (we_cell) cmp("we_on_marked", {31'd0, mark_w}, 0);
    if (chk_req) begin
      if (first_chk_cyc < 0) first_chk_cyc = cyc;
      if (!seen_we) chk_before_we++;
      if (seen_dec && post_dec_cand < 0) post_dec_cand = int'(cell_value);
      pend = 1; dly = $urandom_range(dmax, dmin); pend_val = int'(cell_value);
      observe(EV_CHK + int'(cell_value));
    end
    if (we_cell) begin
      if (first_we_cyc < 0) first_we_cyc = cyc;
      seen_we = 1;
      sched_wr = 1; sched_wr_addr = addr; sched_wr_val = int'(cell_value);
      observe(EV_WR + int'(cell_value));
    end
    if (addr_inc) begin
      if (first_inc_cyc < 0) first_inc_cyc = cyc;
      sched_delta = 1;
      observe(EV_INC + int'(cell_value));
    end
    if (addr_dec) begin
      seen_dec = 1;
      sched_delta = -1;
      observe(EV_DEC + int'(cell_value));
    end
  endtask

  task automatic apply();
    if (sched_wr != 0)
      mem_val[sched_wr_addr] = (tamp[sched_wr_addr] >= 0) ? tamp[sched_wr_addr] : sched_wr_val;
    sched_wr = 0;
    if ((addr + sched_delta) >= 0 && (addr + sched_delta) < NC) addr = addr + sched_delta;
    sched_delta = 0;
    if (pend != 0) begin
      if (dly == 0) begin
        chk_ack = 1'b1;
        chk_ok  = ((mask[addr] >> pend_val) & 1) == 1;
        pend    = 0;
      end else begin
        dly--;
        chk_ack = 1'b0;
        chk_ok  = 1'($urandom);
      end
    end else if (spur_en) begin
      chk_ack = 1'($urandom);
      chk_ok  = 1'($urandom);
    end else begin
      chk_ack = 1'b0;
      chk_ok  = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    apply();
  endtask

  task automatic reset_dut();
    rst = 1'b1; init_done = 1'b0; chk_ack = 1'b0; chk_ok = 1'b0;
    pend = 0; sched_wr = 0; sched_delta = 0; addr = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_outputs", outs(), 0);
    rst = 1'b0;
  endtask

  task automatic fill(input int mk);
    for (int i = 0; i < NC; i++) begin
      mem_mark[i] = 1'b0; mem_val[i] = 0; mask[i] = mk; tamp[i] = -1;
    end
  endtask

  task automatic start_run(input int dlo, input int dhi, input bit spur);
    dmin = dlo; dmax = dhi; spur_en = spur;
    exp_q.delete(); term = 0; m_addr = 0; cyc = 0;
    first_chk_cyc = -1; first_we_cyc = -1; first_inc_cyc = -1; post_dec_cand = -1;
    chk_before_we = 0; seen_we = 0; seen_dec = 0;
    enter(0, 0);
    init_done = 1'b1;
  endtask

  task automatic run_to_end(input int budget);
    int k = 0;
    while (!(done | fail) && k < budget) begin step(); k++; end
    cmp("terminated", {31'd0, done | fail}, 1);
    cmp("done_flag", {31'd0, done}, (term == 1) ? 1 : 0);
    cmp("fail_flag", {31'd0, fail}, (term == 2) ? 1 : 0);
    cmp("events_left", exp_q.size(), 0);
    repeat (3) step();
    cmp("terminal_held", {30'd0, done, fail}, (term == 1) ? 2 : 1);
    cmp("terminal_value", {28'd0, cell_value}, 0);
  endtask

  initial begin
    // Single chain accepting 1 everywhere: exact timing of first check/write/increment.
    fill(1 << 1);
    reset_dut();
    start_run(0, 0, 1'b0);
    run_to_end(20000);
    cmp("first_chk_cycle", first_chk_cyc, 3);
    cmp("first_we_cycle", first_we_cyc, 5);
    cmp("first_inc_cycle", first_inc_cyc, 6);

    // Cell 0 only accepts 9: nine requests before the first write.
    fill(1 << 1);
    mask[0] = 1 << 9;
    reset_dut();
    start_run(0, 1, 1'b1);
    run_to_end(20000);
    cmp("chk_before_first_write", chk_before_we, 9);

    // Backtracking: dead cell 5, marked cell 3, stale 9 and 15 left in cells 1 and 2.
    fill(1 << 1);
    mask[4] = (1 << 3) | (1 << 5);
    mask[5] = 0;
    mem_mark[3] = 1'b1; mem_val[3] = 7;
    tamp[1] = 9; tamp[2] = 15;
    reset_dut();
    start_run(0, 2, 1'b1);
    run_to_end(20000);
    cmp("first_cand_after_backtrack", post_dec_cand, 4);

    // Reset while waiting for the checker; a late ack must not revive the FSM.
    fill(1 << 4);
    reset_dut();
    start_run(5, 5, 1'b0);
    for (int k = 0; k < 20 && pend == 0; k++) step();
    cmp("reached_wait", pend, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; init_done = 1'b0; pend = 0; sched_wr = 0; sched_delta = 0;
    @(negedge clk);
    cmp("outs_after_mid_wait_reset", outs(), 0);
    chk_ack = 1'b1; chk_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmp("late_ack_ignored", outs(), 0);
    end
    chk_ack = 1'b0; chk_ok = 1'b0;

    // Random puzzles; odd runs plant an unsatisfiable cell near the top.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NC; i++) begin
        mem_mark[i] = ($urandom_range(3, 0) == 0);
        mem_val[i]  = mem_mark[i] ? int'($urandom_range(MAXV, 1)) : 0;
        mask[i] = 0;
        tamp[i] = -1;
        for (int b = 0; b <= int'($urandom_range(2, 0)); b++)
          mask[i] = mask[i] | (1 << $urandom_range(MAXV, 1));
      end
      if ((r % 2) == 1) begin
        int d = int'($urandom_range(3, 1));
        mem_mark[d] = 1'b0; mem_val[d] = 0; mask[d] = 0;
      end
      reset_dut();
      start_run(0, 3, 1'b1);
      run_to_end(20000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
